// File: rtl/face_classifier_mac_acc_pkg.sv
// Shared types and defaults for the face classifier MAC accumulator stage.
package face_classifier_pkg;

  typedef enum logic {ST_ACC, ST_OUT} state_t;

  localparam int DIN_W_D  = 13;
  localparam int DOUT_W_D = 13;
  localparam int ACC_W_D  = 21;

  // Signed saturation of a default-width accumulator down to the default output width.
  function automatic logic signed [DOUT_W_D-1:0] sat_s(input logic signed [ACC_W_D-1:0] acc);
    logic signed [DOUT_W_D-1:0] r;
    r = acc[DOUT_W_D-1:0];
    if (!acc[ACC_W_D-1] && (|acc[ACC_W_D-2:DOUT_W_D-1]))
      r = {1'b0, {(DOUT_W_D-1){1'b1}}};
    else if (acc[ACC_W_D-1] && !(&acc[ACC_W_D-2:DOUT_W_D-1]))
      r = {1'b1, {(DOUT_W_D-1){1'b0}}};
    return r;
  endfunction

endpackage

// File: rtl/face_classifier_mac_acc_if.sv
// Product-in / neuron-out handshake bundle for the MAC accumulator stage.
interface face_classifier_mac_acc_if
  import face_classifier_pkg::*;
#(
  parameter int DIN_W  = DIN_W_D,
  parameter int DOUT_W = DOUT_W_D
);
  logic signed [DIN_W-1:0]  bias;
  logic signed [DIN_W-1:0]  in_data;
  logic                     in_last;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DOUT_W-1:0] out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     err_last;

  modport master (
    output bias, in_data, in_last, in_valid, out_ready,
    input  in_ready, out_data, out_valid, err_last
  );

  modport slave (
    input  bias, in_data, in_last, in_valid, out_ready,
    output in_ready, out_data, out_valid, err_last
  );
endinterface

// File: rtl/face_classifier_mac_acc_sat.sv
// Combinational signed saturation ACC_W -> DOUT_W.
// FACE_CLASSIFIER_MAC_ACC_RELU_EN: clamp negative saturated results to zero.
module face_classifier_sat #(
  parameter int ACC_W  = 21,
  parameter int DOUT_W = 13
) (
  input  logic signed [ACC_W-1:0]  i_acc,
  output logic signed [DOUT_W-1:0] o_dout
);
  logic                     w_pos_ovf;
  logic                     w_neg_ovf;
  logic signed [DOUT_W-1:0] w_sat;

  // Overflow whenever the bits above the output sign are not a pure sign extension.
  assign w_pos_ovf = ~i_acc[ACC_W-1] &  (|i_acc[ACC_W-2:DOUT_W-1]);
  assign w_neg_ovf =  i_acc[ACC_W-1] & ~(&i_acc[ACC_W-2:DOUT_W-1]);

  always_comb begin
    w_sat = i_acc[DOUT_W-1:0];
    if (w_pos_ovf)      w_sat = {1'b0, {(DOUT_W-1){1'b1}}};
    else if (w_neg_ovf) w_sat = {1'b1, {(DOUT_W-1){1'b0}}};
  end

`ifdef FACE_CLASSIFIER_MAC_ACC_RELU_EN
  assign o_dout = w_sat[DOUT_W-1] ? '0 : w_sat;
`else
  assign o_dout = w_sat;
`endif

endmodule

// File: rtl/face_classifier_mac_acc.sv
// Accumulates NUM_TERMS signed products plus bias into one saturated neuron output.
// Optional ReLU via FACE_CLASSIFIER_MAC_ACC_RELU_EN (applied inside face_classifier_sat).
module face_classifier_mac_acc
  import face_classifier_pkg::*;
#(
  parameter int DIN_W     = DIN_W_D,
  parameter int NUM_TERMS = 64,
  parameter int ACC_W     = ACC_W_D,
  parameter int DOUT_W    = DOUT_W_D
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  face_classifier_mac_acc_if.slave  bus
);
  localparam int CNT_W = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_TERMS - 1);

  state_t                   r_state, w_state_nxt;
  logic [CNT_W-1:0]         r_cnt;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [DOUT_W-1:0] r_out;
  logic                     r_err;

  logic signed [ACC_W-1:0]  w_din_x, w_bias_x, w_acc_nxt;
  logic signed [DOUT_W-1:0] w_sat;
  logic                     w_in_ready, w_out_valid, w_accept, w_last_term;

  assign w_din_x     = {{(ACC_W-DIN_W){bus.in_data[DIN_W-1]}}, bus.in_data};
  assign w_bias_x    = {{(ACC_W-DIN_W){bus.bias[DIN_W-1]}}, bus.bias};
  assign w_last_term = (r_cnt == LAST);
  assign w_accept    = bus.in_valid & w_in_ready;
  // First term of a neuron starts from the bias rather than the stale accumulator.
  assign w_acc_nxt   = ((r_cnt == '0) ? w_bias_x : r_acc) + w_din_x;

  face_classifier_sat #(.ACC_W(ACC_W), .DOUT_W(DOUT_W)) u_sat (
    .i_acc  (w_acc_nxt),
    .o_dout (w_sat)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) r_state <= ST_ACC;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      ST_ACC: begin
        w_in_ready = 1'b1;
        if (w_accept && w_last_term) w_state_nxt = ST_OUT;
      end
      ST_OUT: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_state_nxt = ST_ACC;
      end
      default: w_state_nxt = ST_ACC;
    endcase
  end

  // The counter alone decides neuron boundaries; in_last is only cross-checked.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_cnt <= '0;
      r_acc <= '0;
      r_out <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_accept & (bus.in_last != w_last_term);
      if (w_accept) begin
        r_acc <= w_acc_nxt;
        if (w_last_term) begin
          r_cnt <= '0;
          r_out <= w_sat;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_out;
  assign bus.err_last  = r_err;

endmodule

// File: tb/tb_face_classifier_mac_acc.sv
// Self-checking bench for face_classifier_mac_acc with NUM_TERMS=4 and a sum-and-clamp model.
module tb_face_classifier_mac_acc;
  localparam int NT = 4;

  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b0;
  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   err_seen = 0;
  logic signed [12:0] got_q[$];

  face_classifier_mac_acc_if #(.DIN_W(13), .DOUT_W(13)) bus ();

  face_classifier_mac_acc #(.DIN_W(13), .NUM_TERMS(NT), .ACC_W(21), .DOUT_W(13)) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus)
  );

  always #5 ap_clk = ~ap_clk;

  always @(negedge ap_clk) begin
    if (bus.err_last === 1'b1) err_seen++;
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) got_q.push_back(bus.out_data);
  end

  function automatic int model(input int b, input int p[NT]);
    int s;
    s = b;
    foreach (p[i]) s += p[i];
    if (s > 4095)  s = 4095;
    if (s < -4096) s = -4096;
`ifdef FACE_CLASSIFIER_MAC_ACC_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the term was accepted.
  task automatic drive_term(input int b, input int d, input bit l);
    int   w;
    logic rdy;
    bus.bias = 13'(b); bus.in_data = 13'(d); bus.in_last = l; bus.in_valid = 1'b1;
    w = 0;
    do begin
      @(negedge ap_clk); rdy = bus.in_ready;
      @(posedge ap_clk); w++;
    end while (rdy !== 1'b1 && w < 50);
    if (rdy !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL in_ready_timeout: in_ready=%b after %0d cycles, required 1", rdy, w);
    end
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic run_neuron(input int b, input int p[NT], input int last_at);
    for (int t = 0; t < NT; t++) drive_term(b, p[t], t == last_at);
  endtask

  // Output must be present at the negedge straight after the final accept.
  task automatic check_out(input string name, input int exp);
    @(negedge ap_clk);
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 13'(exp)) begin
      n_bad++;
      $display("FAIL %s: out_valid=%b out_data=%0d, required valid=1 data=%0d",
               name, bus.out_valid, $signed(bus.out_data), exp);
    end
    @(posedge ap_clk); #1;
  endtask

  task automatic test_reset;
    bus.bias = '0; bus.in_data = '0; bus.in_last = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    ap_rst_n = 1'b0;
    #2;
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 13'sd0 || bus.err_last !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: in_ready=%b out_valid=%b out_data=%0d err_last=%b, required 1/0/0/0",
               bus.in_ready, bus.out_valid, $signed(bus.out_data), bus.err_last);
    end
    repeat (2) @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
  endtask

  task automatic test_basic;
    int p[NT] = '{1, 2, 3, 4};
    int e0;
    e0 = err_seen;
    run_neuron(10, p, 3);
    check_out("basic_sum", 20);
    n_cmp++;
    if (err_seen - e0 != 0) begin
      n_bad++;
      $display("FAIL basic_err_last: pulses=%0d, required 0", err_seen - e0);
    end
  endtask

  task automatic test_saturation;
    int pmax[NT] = '{4095, 4095, 4095, 4095};
    int pmin[NT] = '{-4096, -4096, -4096, -4096};
    run_neuron(4095, pmax, 3);
    check_out("sat_max", model(4095, pmax));
    run_neuron(-4096, pmin, 3);
    check_out("sat_min", model(-4096, pmin));
  endtask

  task automatic test_backpressure;
    int p[NT] = '{-7, 100, 33, -2};
    int exp;
    exp = model(-50, p);
    bus.out_ready = 1'b0;
    run_neuron(-50, p, 3);
    for (int c = 0; c < 5; c++) begin
      @(negedge ap_clk);
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 13'(exp) || bus.in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL backpressure_hold[%0d]: valid=%b data=%0d in_ready=%b, required 1/%0d/0",
                 c, bus.out_valid, $signed(bus.out_data), bus.in_ready, exp);
      end
    end
    #1 bus.out_ready = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL backpressure_release: in_ready=%b out_valid=%b, required 1/0",
               bus.in_ready, bus.out_valid);
    end
    @(posedge ap_clk); #1;
  endtask

  task automatic test_back_to_back;
    int exp_q[$];
    int p[NT];
    int b, amp;
    got_q.delete();
    for (int n = 0; n < 3; n++) begin
      amp = (n == 0) ? 300 : 4095;
      b = $urandom_range(0, 2 * amp) - amp;
      for (int t = 0; t < NT; t++) p[t] = $urandom_range(0, 2 * amp) - amp;
      exp_q.push_back(model(b, p));
      for (int t = 0; t < NT; t++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge ap_clk); #1; end
        // Bias on later terms is junk and must be ignored.
        drive_term((t == 0) ? b : int'($urandom_range(0, 8191)) - 4096, p[t], t == NT - 1);
      end
    end
    repeat (4) begin @(posedge ap_clk); #1; end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL b2b_count: outputs=%0d, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== 13'(exp_q[i])) begin
        n_bad++;
        $display("FAIL b2b_sum[%0d]: out_data=%0d, required %0d", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_err_last;
    int p[NT] = '{50, -20, 7, 9};
    int e0;
    e0 = err_seen;
    drive_term(3, p[0], 1'b0);
    drive_term(3, p[1], 1'b1);
    @(negedge ap_clk);
    n_cmp++;
    if (bus.err_last !== 1'b1) begin
      n_bad++;
      $display("FAIL err_last_pulse: err_last=%b, required 1", bus.err_last);
    end
    @(negedge ap_clk);
    n_cmp++;
    if (bus.err_last !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL err_last_width: err_last=%b out_valid=%b, required 0/0", bus.err_last, bus.out_valid);
    end
    @(posedge ap_clk); #1;
    drive_term(3, p[2], 1'b0);
    drive_term(3, p[3], 1'b1);
    check_out("err_last_full_sum", model(3, p));
    n_cmp++;
    if (err_seen - e0 != 1) begin
      n_bad++;
      $display("FAIL err_last_count: pulses=%0d, required 1", err_seen - e0);
    end
  endtask

  task automatic test_reset_mid;
    int ov;
    int p[NT] = '{1, 1, 1, 1};
    drive_term(100, 5, 1'b0);
    drive_term(100, 6, 1'b0);
    ap_rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== 13'sd0) begin
      n_bad++;
      $display("FAIL reset_mid_outputs: out_valid=%b in_ready=%b out_data=%0d, required 0/1/0",
               bus.out_valid, bus.in_ready, $signed(bus.out_data));
    end
    repeat (2) @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    ov = 0;
    repeat (8) begin
      @(negedge ap_clk);
      if (bus.out_valid !== 1'b0) ov++;
    end
    n_cmp++;
    if (ov != 0) begin
      n_bad++;
      $display("FAIL reset_mid_no_output: out_valid cycles=%0d, required 0", ov);
    end
    @(posedge ap_clk); #1;
    run_neuron(0, p, 3);
    check_out("reset_mid_next_neuron", 4);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_back_to_back();
    test_err_last();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
